lc3_control_fsm: RTL

Instruction-sequencing controller for the LC-3 core. It drives the fetch unit (fetch_start), IR load, decode, execute, memory access and register writeback, one instruction at a time. It walks a multi-cycle state machine keyed on the latched opcode. It inserts a configurable number of memory wait cycles and stops the core on TRAP x25 (HALT) or an illegal opcode.

---
 rtl/lc3_control_fsm.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/lc3_control_fsm.sv
// LC-3 instruction-sequencing controller: multi-cycle FSM with MEM_LAT-cycle memory waits.
// Optional single-step mode (return to IDLE after each instruction) when LC3_STEP_EN is defined.
module lc3_control_fsm #(
    parameter int          MEM_LAT   = 2,
    parameter logic [7:0]  HALT_VECT = 8'h25
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] opcode_in,
    input  logic [7:0] trap_vect_in,
    output logic       fetch_start,
    output logic       ir_load,
    output logic       decode_en,
    output logic       exec_en,
    output logic       mem_en,
    output logic       mem_we,
    output logic [1:0] addr_sel,
    output logic       pc_load,
    output logic       wb_en,
    output logic       nzp_load,
    output logic       halted,
    output logic [3:0] state_out
);

    typedef enum logic [3:0] {
        S_IDLE         = 4'd0,
        S_FETCH        = 4'd1,
        S_FETCH_WAIT   = 4'd2,
        S_DECODE       = 4'd3,
        S_EXECUTE      = 4'd4,
        S_MEM_IND      = 4'd5,
        S_MEM_IND_WAIT = 4'd6,
        S_MEM          = 4'd7,
        S_MEM_WAIT     = 4'd8,
        S_WRITEBACK    = 4'd9,
        S_HALT         = 4'd10
    } state_t;

    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_LD   = 4'b0010;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_JSR  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_LDR  = 4'b0110;
    localparam logic [3:0] OP_STR  = 4'b0111;
    localparam logic [3:0] OP_RTI  = 4'b1000;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_LDI  = 4'b1010;
    localparam logic [3:0] OP_STI  = 4'b1011;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_RSV  = 4'b1101;
    localparam logic [3:0] OP_TRAP = 4'b1111;

    localparam logic [2:0] WAIT_INIT = 3'(MEM_LAT - 1);

`ifdef LC3_STEP_EN
    localparam state_t S_DONE = S_IDLE;
`else
    localparam state_t S_DONE = S_FETCH;
`endif

    state_t     state_reg, state_next;
    logic [2:0] cnt_reg, cnt_next;
    logic [3:0] op_reg, op_next;

    logic       fetch_start_next, ir_load_next, decode_en_next, exec_en_next;
    logic       mem_en_next, mem_we_next, pc_load_next, wb_en_next;
    logic       nzp_load_next, halted_next;
    logic [1:0] addr_sel_next;

    function automatic logic is_store(input logic [3:0] op);
        return (op == OP_ST) || (op == OP_STR) || (op == OP_STI);
    endfunction

    function automatic logic is_indirect(input logic [3:0] op);
        return (op == OP_LDI) || (op == OP_STI);
    endfunction

    // Next-state, wait counter and opcode latch.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        op_next    = op_reg;
        case (state_reg)
            S_IDLE: if (start) state_next = S_FETCH;
            S_FETCH: begin
                state_next = S_FETCH_WAIT;
                cnt_next   = WAIT_INIT;
            end
            S_FETCH_WAIT: begin
                if (cnt_reg == 3'd0) state_next = S_DECODE;
                else                 cnt_next   = cnt_reg - 3'd1;
            end
            S_DECODE: begin
                op_next = opcode_in;
                // The halt vector is judged here, in the only cycle it matters.
                if ((opcode_in == OP_RSV) || (opcode_in == OP_RTI) ||
                    ((opcode_in == OP_TRAP) && (trap_vect_in == HALT_VECT)))
                    state_next = S_HALT;
                else
                    state_next = S_EXECUTE;
            end
            S_EXECUTE: begin
                case (op_reg)
                    OP_BR, OP_JMP:          state_next = S_DONE;
                    OP_JSR, OP_TRAP:        state_next = S_WRITEBACK;
                    OP_LD, OP_ST,
                    OP_LDR, OP_STR:         state_next = S_MEM;
                    OP_LDI, OP_STI:         state_next = S_MEM_IND;
                    default:                state_next = S_WRITEBACK;
                endcase
            end
            S_MEM_IND: begin
                state_next = S_MEM_IND_WAIT;
                cnt_next   = WAIT_INIT;
            end
            S_MEM_IND_WAIT: begin
                if (cnt_reg == 3'd0) state_next = S_MEM;
                else                 cnt_next   = cnt_reg - 3'd1;
            end
            S_MEM: begin
                if (is_store(op_reg)) begin
                    state_next = S_DONE;
                end else begin
                    state_next = S_MEM_WAIT;
                    cnt_next   = WAIT_INIT;
                end
            end
            S_MEM_WAIT: begin
                if (cnt_reg == 3'd0) state_next = S_WRITEBACK;
                else                 cnt_next   = cnt_reg - 3'd1;
            end
            S_WRITEBACK: state_next = S_DONE;
            S_HALT:      state_next = S_HALT;
            default:     state_next = S_IDLE;
        endcase
    end

    // Moore outputs decoded from the upcoming state so they register in step with it.
    always_comb begin
        fetch_start_next = 1'b0;
        ir_load_next     = 1'b0;
        decode_en_next   = 1'b0;
        exec_en_next     = 1'b0;
        mem_en_next      = 1'b0;
        mem_we_next      = 1'b0;
        addr_sel_next    = 2'b00;
        pc_load_next     = 1'b0;
        wb_en_next       = 1'b0;
        nzp_load_next    = 1'b0;
        halted_next      = 1'b0;
        case (state_next)
            S_FETCH: begin
                fetch_start_next = 1'b1;
                mem_en_next      = 1'b1;
            end
            S_FETCH_WAIT: ir_load_next = (cnt_next == 3'd0);
            S_DECODE:     decode_en_next = 1'b1;
            S_EXECUTE: begin
                exec_en_next = 1'b1;
                pc_load_next = (op_next == OP_BR) || (op_next == OP_JMP) ||
                               (op_next == OP_JSR) || (op_next == OP_TRAP);
            end
            S_MEM_IND: begin
                mem_en_next   = 1'b1;
                addr_sel_next = 2'b01;
            end
            S_MEM: begin
                mem_en_next   = 1'b1;
                mem_we_next   = is_store(op_next);
                addr_sel_next = is_indirect(op_next) ? 2'b10 : 2'b01;
            end
            S_WRITEBACK: begin
                wb_en_next    = 1'b1;
                nzp_load_next = (op_next == OP_ADD) || (op_next == OP_AND) ||
                                (op_next == OP_NOT) || (op_next == OP_LD)  ||
                                (op_next == OP_LDR) || (op_next == OP_LDI);
            end
            S_HALT:  halted_next = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= 3'd0;
            op_reg      <= 4'd0;
            fetch_start <= 1'b0;
            ir_load     <= 1'b0;
            decode_en   <= 1'b0;
            exec_en     <= 1'b0;
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            addr_sel    <= 2'b00;
            pc_load     <= 1'b0;
            wb_en       <= 1'b0;
            nzp_load    <= 1'b0;
            halted      <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            op_reg      <= op_next;
            fetch_start <= fetch_start_next;
            ir_load     <= ir_load_next;
            decode_en   <= decode_en_next;
            exec_en     <= exec_en_next;
            mem_en      <= mem_en_next;
            mem_we      <= mem_we_next;
            addr_sel    <= addr_sel_next;
            pc_load     <= pc_load_next;
            wb_en       <= wb_en_next;
            nzp_load    <= nzp_load_next;
            halted      <= halted_next;
        end
    end

    assign state_out = state_reg;

endmodule
